// File: rtl/i2c_pkg.sv
// Shared definitions for the FND I2C write controller: bus FSM states,
// default slave address, quarter-period counts and the requester arbiter.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP
  } i2c_state_t;

  localparam logic [6:0] FND_ADDR  = 7'h56;
  localparam int         START_Q   = 2;
  localparam int         BIT_Q     = 4;
  localparam int         STOP_Q    = 4;
  localparam int         BYTE_BITS = 8;

  // One-hot winner; on contention the requester not served last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_id);
    if (req == 2'b11) return last_id ? 2'b01 : 2'b10;
    return req;
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period tick generator: one pulse every CLK_DIV clocks, restartable.
module i2c_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  logic [15:0] cnt;
  logic        wrap;

  assign wrap = (cnt == 16'(CLK_DIV - 1));
  assign tick = wrap && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (clear || wrap) cnt <= '0;
    else                    cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/i2c_fnd_ctrl.sv
// Two-requester I2C master that writes one hex digit to a 7-segment (FND)
// slave: START, address byte, data byte {4'h0,digit}, STOP.
module i2c_fnd_ctrl
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV    = 250,
  parameter logic [6:0] SLAVE_ADDR = FND_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  output logic [1:0] grant,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       done_id,
  output logic       scl,
  inout  wire        sda
);

  i2c_state_t  state;
  logic [1:0]  q;
  logic [2:0]  bit_idx;
  logic [3:0]  digit;
  logic        id;
  logic        last_id;
  logic        armed;
  logic        sda_low;
  logic        ack_n;
  logic        nack_flag;
  logic [1:0]  sda_sync;
  logic [1:0]  pick;
  logic        take;
  logic        tick;
  logic [7:0]  addr_byte;
  logic [7:0]  data_byte;
  logic [7:0]  tx_byte;

  assign sda       = sda_low ? 1'b0 : 1'bz;
  assign addr_byte = {SLAVE_ADDR, 1'b0};
  assign data_byte = {4'h0, digit};
  assign tx_byte   = (state == ADDR) ? addr_byte : data_byte;
  assign pick      = rr_pick(req, last_id);
  // done is high in the first IDLE cycle, so a waiting request is taken after it
  assign take      = (state == IDLE) && armed && !done && (req != 2'b00);

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(take),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sda_sync <= 2'b11;
    else        sda_sync <= {sda_sync[0], sda};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= '0;
      bit_idx   <= '0;
      digit     <= '0;
      id        <= 1'b0;
      last_id   <= 1'b1;
      armed     <= 1'b0;
      grant     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      done_id   <= 1'b0;
      scl       <= 1'b1;
      sda_low   <= 1'b0;
      ack_n     <= 1'b0;
      nack_flag <= 1'b0;
    end else begin
      armed   <= 1'b1;
      grant   <= '0;
      done    <= 1'b0;
      nack    <= 1'b0;
      done_id <= 1'b0;
      if (grant != 2'b00) busy <= 1'b1;

      if (take) begin
        grant   <= pick;
        id      <= pick[1];
        last_id <= pick[1];
        digit   <= pick[1] ? digit1 : digit0;
        state   <= START;
        q       <= '0;
        scl     <= 1'b1;
        sda_low <= 1'b1;
      end else if (tick) begin
        // outputs registered here hold for the whole following quarter
        case (state)
          START: begin
            if (q == 2'(START_Q - 1)) begin
              state   <= ADDR;
              q       <= '0;
              bit_idx <= 3'(BYTE_BITS - 1);
              scl     <= 1'b0;
              sda_low <= ~addr_byte[7];
            end else begin
              q <= q + 2'd1;
            end
          end
          ADDR, DATA: begin
            if (q == 2'(BIT_Q - 1)) begin
              q   <= '0;
              scl <= 1'b0;
              if (bit_idx == 3'd0) begin
                state   <= (state == ADDR) ? ADDR_ACK : DATA_ACK;
                sda_low <= 1'b0;
              end else begin
                bit_idx <= bit_idx - 3'd1;
                sda_low <= ~tx_byte[bit_idx - 3'd1];
              end
            end else begin
              q <= q + 2'd1;
              if (q == 2'd1) scl <= 1'b1;
            end
          end
          ADDR_ACK, DATA_ACK: begin
            if (q == 2'd2) ack_n <= sda_sync[1];
            if (q == 2'(BIT_Q - 1)) begin
              q   <= '0;
              scl <= 1'b0;
              if (state == ADDR_ACK && !ack_n) begin
                state   <= DATA;
                bit_idx <= 3'(BYTE_BITS - 1);
                sda_low <= ~data_byte[7];
              end else begin
                state     <= STOP;
                sda_low   <= 1'b1;
                nack_flag <= ack_n;
              end
            end else begin
              q <= q + 2'd1;
              if (q == 2'd1) scl <= 1'b1;
            end
          end
          STOP: begin
            q <= q + 2'd1;
            if (q == 2'd0) begin
              scl <= 1'b1;
            end else if (q == 2'd1) begin
              sda_low <= 1'b0;
            end else if (q == 2'(STOP_Q - 1)) begin
              state   <= IDLE;
              q       <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              nack    <= nack_flag;
              done_id <= id;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_fnd_ctrl.sv
// Bench for i2c_fnd_ctrl: behavioural FND slave on a pulled-up bus plus a
// transaction-level model of arbitration, timing, bytes and display contents.
module tb_i2c_fnd_ctrl;

  localparam int D      = 8;
  localparam int FULL_Q = 78;
  localparam int NAK_Q  = 42;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] digit0 = 4'h0;
  logic [3:0] digit1 = 4'h0;
  logic [1:0] grant;
  logic       busy, done, nack, done_id, scl;
  wire        sda;

  int n_chk = 0, n_err = 0, cyc = 0;
  int n_gnt = 0, gnt_bad = 0, m_gnts = 0;

  i2c_fnd_ctrl #(.CLK_DIV(D), .SLAVE_ADDR(7'h56)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .digit0 (digit0),
    .digit1 (digit1),
    .grant  (grant),
    .busy   (busy),
    .done   (done),
    .nack   (nack),
    .done_id(done_id),
    .scl    (scl),
    .sda    (sda)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- FND slave model (active-low gfedcba segments) ----------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[d];
  endfunction

  logic [6:0] slv_addr = 7'h56;
  logic       slv_nak_data = 1'b0;
  logic       slv_low = 1'b0, active = 1'b0, ack_ph = 1'b0, addr_ok = 1'b0;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic [7:0] sh = 8'h00;
  int         bcnt = 0, byte_idx = 0, rx_n = 0, starts = 0, stops = 0, rises = 0;
  logic [7:0] rx_mem [256];
  logic [3:0] slv_digit = 4'h0;
  logic [6:0] slv_seg;

  assign sda = slv_low ? 1'b0 : 1'bz;
  pullup (sda);
  assign slv_seg = seg7(slv_digit);

  always @(posedge clk) begin
    p_scl <= scl;
    p_sda <= sda;
    if (p_scl && scl && p_sda && !sda) begin
      starts <= starts + 1; active <= 1'b1; bcnt <= 0; byte_idx <= 0;
      ack_ph <= 1'b0; slv_low <= 1'b0;
    end else if (p_scl && scl && !p_sda && sda) begin
      stops <= stops + 1; active <= 1'b0; slv_low <= 1'b0;
    end else if (!p_scl && scl) begin
      rises <= rises + 1;
      if (active && !ack_ph && bcnt < 8) begin
        sh <= {sh[6:0], sda}; bcnt <= bcnt + 1;
      end
    end else if (p_scl && !scl && active) begin
      if (ack_ph) begin
        ack_ph <= 1'b0; slv_low <= 1'b0; bcnt <= 0;
      end else if (bcnt == 8) begin
        ack_ph <= 1'b1;
        rx_mem[rx_n % 256] <= sh;
        rx_n <= rx_n + 1;
        byte_idx <= byte_idx + 1;
        if (byte_idx == 0) begin
          addr_ok <= (sh == {slv_addr, 1'b0});
          slv_low <= (sh == {slv_addr, 1'b0});
        end else if (addr_ok && !slv_nak_data) begin
          slv_low <= 1'b1; slv_digit <= sh[3:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (grant != 2'b00) begin
      n_gnt <= n_gnt + 1;
      if (busy || done || grant == 2'b11) gnt_bad <= gnt_bad + 1;
    end
  end

  // ---------------- checking and reference model ---------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic       m_last = 1'b1;
  logic [3:0] m_digit = 4'h0;

  // Serve up to n requests; with hold the winner's req stays up until the last.
  task automatic serve(input int n, input bit hold);
    int w, g_cyc, d_cyc, rx0, st0, sp0, rs0;
    logic [1:0] exp_g;
    logic [3:0] dg;
    bit ack_a, ack_d;
    d_cyc = -1;
    for (int k = 0; k < n && req != 2'b00; k++) begin
      exp_g = (req == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req;
      dg    = exp_g[1] ? digit1 : digit0;
      rx0 = rx_n; st0 = starts; sp0 = stops; rs0 = rises;
      w = 0;
      while (grant == 2'b00 && w < 200) begin @(negedge clk); w++; end
      chk("grant", grant, exp_g);
      if (grant == 2'b00) return;
      g_cyc = cyc;
      m_gnts++;
      if (d_cyc >= 0) chk("grant_after_done", (g_cyc - d_cyc) >= 1, 1);
      m_last = exp_g[1];
      if (!hold || k == n - 1) req = req & ~exp_g;
      @(negedge clk);
      chk("busy_set", busy, 1);
      ack_a = (slv_addr == 7'h56);
      ack_d = ack_a && !slv_nak_data;
      w = 0;
      while (!done && w < 1000) begin @(negedge clk); w++; end
      d_cyc = cyc;
      chk("latency", d_cyc - g_cyc, (ack_a ? FULL_Q : NAK_Q) * D);
      chk("nack", nack, !ack_d);
      chk("done_id", done_id, exp_g[1]);
      chk("busy_at_done", busy, 0);
      chk("byte_count", rx_n - rx0, ack_a ? 2 : 1);
      chk("addr_byte", rx_mem[rx0 % 256], 8'hAC);
      if (ack_a) chk("data_byte", rx_mem[(rx0 + 1) % 256], {4'h0, dg});
      if (ack_d) m_digit = dg;
      chk("seg", slv_seg, seg7(m_digit));
      chk("start_stop", {16'(starts - st0), 16'(stops - sp0)}, {16'd1, 16'd1});
      chk("scl_rises", rises - rs0, ack_a ? 19 : 10);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, g;
    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // both requesters at once straight out of reset: 0 first, then 1
    req = 2'b11; digit0 = 4'h1; digit1 = 4'h2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_first_cycle", grant, 0);
    serve(2, 0);
    chk("seg_two", slv_seg, 7'b0100100);

    req = 2'b01; digit0 = 4'h7;
    serve(1, 0);
    chk("seg_seven", slv_seg, 7'b1111000);

    req = 2'b01; digit0 = 4'hF;
    serve(1, 0);

    req = 2'b10; digit1 = 4'h9;
    serve(3, 1);

    slv_addr = 7'h55; req = 2'b01; digit0 = 4'h3;
    serve(1, 0);
    slv_addr = 7'h56;

    slv_nak_data = 1'b1; req = 2'b10; digit1 = 4'h5;
    serve(1, 0);
    slv_nak_data = 1'b0;

    // reset pulse during DATA bit 3 (SCL low part of that bit)
    req = 2'b01; digit0 = 4'($urandom);
    w = 0;
    while (grant == 2'b00 && w < 200) begin @(negedge clk); w++; end
    chk("abort_grant", grant, 2'b01);
    g = cyc; req = 2'b00; m_gnts++;
    w = 0;
    while ((cyc - g) < 54 * D + 2 && w < 1000) begin @(negedge clk); w++; end
    chk("abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_scl", scl, 1);
    chk("abort_sda", sda, 1);
    chk("abort_busy_clr", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_seg", slv_seg, seg7(m_digit));
    m_last = 1'b1;
    repeat (3) @(negedge clk);
    req = 2'b11; digit0 = 4'hA; digit1 = 4'h4;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_first_cycle", grant, 0);
    serve(2, 0);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      digit0 = 4'($urandom);
      digit1 = 4'($urandom);
      slv_addr = ($urandom_range(0, 4) == 0) ? 7'h55 : 7'h56;
      slv_nak_data = ($urandom_range(0, 4) == 0);
      req = 2'($urandom_range(1, 3));
      serve(2, 0);
    end

    @(negedge clk);
    chk("grant_while_busy", gnt_bad, 0);
    chk("grant_total", n_gnt, m_gnts);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
